// File: rtl/haz_ctrl_pkg.sv
// Shared types, constants and parameter checks for the pipeline hazard controller.
//   inflight_t  : one tracked post-decode stage {valid, rd, reg_write, mem_read}
//   FWD_RF      : forward select meaning "take the register file value"
//   params_ok   : legality check of a controller parameter set
//   writes_src  : match rule between a tracked entry and a source operand
package haz_ctrl_pkg;

   localparam int unsigned RF_AW     = 5;
   localparam int unsigned FWD_RF    = 0;
   localparam int unsigned DEPTH_MIN = 2;
   localparam int unsigned DEPTH_MAX = 7;

   typedef struct packed {
      logic             valid;
      logic [RF_AW-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } inflight_t;

   function automatic logic params_ok(input int unsigned rf_address,
                                      input int unsigned depth,
                                      input int unsigned load_use_dist,
                                      input int unsigned fwd_w);
      return (rf_address >= 1) && (rf_address <= RF_AW) &&
             (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
             (load_use_dist >= 1) && (load_use_dist <= depth - 1) &&
             (fwd_w == $clog2(depth));
   endfunction

   // x0 is hard-wired zero, so it never produces a forwardable result
   function automatic logic writes_src(input inflight_t        e,
                                       input logic [RF_AW-1:0] src,
                                       input logic             src_used);
      return e.valid && e.reg_write && (e.rd != '0) && src_used && (e.rd == src);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the datapath and the hazard controller.
//   master : datapath side, drives the ID/EX/memory status, receives controls
//   slave  : controller side
interface pipe_hazard_ctrl_if #(
   parameter int unsigned RF_ADDRESS = 5,
   parameter int unsigned FWD_W      = 2
);
   logic                  id_valid;
   logic [RF_ADDRESS-1:0] id_rs1;
   logic [RF_ADDRESS-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [RF_ADDRESS-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  ex_flush;
   logic                  mem_busy;

   logic                  if_stall;
   logic                  id_bubble;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic                  pipe_hold;
   logic [FWD_W-1:0]      fwd_a;
   logic [FWD_W-1:0]      fwd_b;
   logic [31:0]           stall_cycles;
   logic [31:0]           flush_count;
   logic [31:0]           hold_cycles;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
             id_reg_write, id_mem_read, ex_flush, mem_busy,
      input  if_stall, id_bubble, if_id_flush, id_ex_flush, pipe_hold,
             fwd_a, fwd_b, stall_cycles, flush_count, hold_cycles
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
             id_reg_write, id_mem_read, ex_flush, mem_busy,
      output if_stall, id_bubble, if_id_flush, id_ex_flush, pipe_hold,
             fwd_a, fwd_b, stall_cycles, flush_count, hold_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// fwd_select: youngest-match priority encoder for one EX operand.
//   older    : tracked entries 1..N (older[j] is pipeline entry j+1)
//   src      : EX source register, src_used: operand actually read
//   sel      : smallest matching entry index, FWD_RF when none
module fwd_select
   import haz_ctrl_pkg::*;
#(
   parameter int unsigned N             = 2,
   parameter int unsigned LOAD_USE_DIST = 1,
   parameter int unsigned FWD_W         = 2
) (
   input  inflight_t        older [N],
   input  logic [RF_AW-1:0] src,
   input  logic             src_used,
   output logic [FWD_W-1:0] sel
);

   // Scan oldest to youngest so the youngest match overwrites older ones;
   // loads still inside the load-use window have no result yet.
   always_comb begin
      sel = FWD_W'(FWD_RF);
      for (int j = int'(N) - 1; j >= 0; j--) begin
         if (writes_src(older[j], src, src_used) &&
             !(((j + 1) < int'(LOAD_USE_DIST)) && older[j].mem_read)) begin
            sel = FWD_W'(j + 1);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for the in-order pipeline.
// Tracks DEPTH post-decode stages (entry 0 = EX), raises load-use stalls,
// branch flushes and the memory-busy global hold, and selects EX operand sources.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipe_hazard_ctrl_if.slave (ID info, flush/busy in; controls out)
// Build option: HAZ_PERF_EN adds saturating stall/flush/hold counters,
// otherwise the counter outputs are tied to 0.
module pipe_hazard_ctrl
   import haz_ctrl_pkg::*;
#(
   parameter int unsigned RF_ADDRESS    = 5,
   parameter int unsigned DEPTH         = 3,
   parameter int unsigned LOAD_USE_DIST = 1,
   parameter int unsigned FWD_W         = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   if (!params_ok(RF_ADDRESS, DEPTH, LOAD_USE_DIST, FWD_W)) begin : g_param_check
      $error("pipe_hazard_ctrl: illegal RF_ADDRESS/DEPTH/LOAD_USE_DIST/FWD_W");
   end

   inflight_t        inflight_q [DEPTH];
   inflight_t        older      [DEPTH-1];
   logic [RF_AW-1:0] ex_rs1_q;
   logic [RF_AW-1:0] ex_rs2_q;
   logic             ex_use1_q;
   logic             ex_use2_q;

   logic [RF_AW-1:0] id_rs1_w;
   logic [RF_AW-1:0] id_rs2_w;
   logic             hold;
   logic             flush;
   logic             load_use_hit;
   logic             load_use;
   logic             id_take;
   inflight_t        id_entry;
   logic [FWD_W-1:0] fwd_a_c;
   logic [FWD_W-1:0] fwd_b_c;

   assign id_rs1_w = RF_AW'(bus.id_rs1);
   assign id_rs2_w = RF_AW'(bus.id_rs2);

   // Hazard decision: hold beats flush, flush beats load-use
   always_comb begin
      load_use_hit = 1'b0;
      for (int unsigned k = 0; k < LOAD_USE_DIST; k++) begin
         if (inflight_q[k].mem_read &&
             (writes_src(inflight_q[k], id_rs1_w, bus.id_uses_rs1) ||
              writes_src(inflight_q[k], id_rs2_w, bus.id_uses_rs2))) begin
            load_use_hit = 1'b1;
         end
      end
   end

   assign hold     = bus.mem_busy;
   assign flush    = bus.ex_flush && !hold;
   assign load_use = bus.id_valid && !bus.ex_flush && !hold && load_use_hit;
   assign id_take  = bus.id_valid && !load_use && !bus.ex_flush;

   assign bus.pipe_hold   = hold;
   assign bus.if_stall    = hold || load_use;
   assign bus.id_bubble   = load_use;
   assign bus.if_id_flush = flush;
   assign bus.id_ex_flush = flush;

   // Entry entering EX; fields are cleared for bubbles so nothing stale matches
   always_comb begin
      id_entry = '0;
      if (id_take) begin
         id_entry.valid     = 1'b1;
         id_entry.rd        = RF_AW'(bus.id_rd);
         id_entry.reg_write = bus.id_reg_write;
         id_entry.mem_read  = bus.id_mem_read;
      end
   end

   // In-flight tracking: shifts one stage per un-held edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) inflight_q[k] <= '0;
         ex_rs1_q  <= '0;
         ex_rs2_q  <= '0;
         ex_use1_q <= 1'b0;
         ex_use2_q <= 1'b0;
      end else if (!hold) begin
         for (int unsigned k = DEPTH - 1; k > 0; k--) inflight_q[k] <= inflight_q[k-1];
         inflight_q[0] <= id_entry;
         ex_rs1_q      <= id_take ? id_rs1_w : '0;
         ex_rs2_q      <= id_take ? id_rs2_w : '0;
         ex_use1_q     <= id_take && bus.id_uses_rs1;
         ex_use2_q     <= id_take && bus.id_uses_rs2;
      end
   end

   // Entry 0 is the EX instruction itself and never a forwarding source
   always_comb begin
      for (int unsigned j = 0; j < DEPTH - 1; j++) older[j] = inflight_q[j+1];
   end

   fwd_select #(
      .N             (DEPTH - 1),
      .LOAD_USE_DIST (LOAD_USE_DIST),
      .FWD_W         (FWD_W)
   ) u_fwd_a (
      .older    (older),
      .src      (ex_rs1_q),
      .src_used (ex_use1_q),
      .sel      (fwd_a_c)
   );

   fwd_select #(
      .N             (DEPTH - 1),
      .LOAD_USE_DIST (LOAD_USE_DIST),
      .FWD_W         (FWD_W)
   ) u_fwd_b (
      .older    (older),
      .src      (ex_rs2_q),
      .src_used (ex_use2_q),
      .sel      (fwd_b_c)
   );

   assign bus.fwd_a = fwd_a_c;
   assign bus.fwd_b = fwd_b_c;

`ifdef HAZ_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;
   logic [31:0] hold_q;

   // Saturating event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
         hold_q  <= '0;
      end else begin
         if (load_use && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (flush    && (flush_q != '1)) flush_q <= flush_q + 32'd1;
         if (hold     && (hold_q  != '1)) hold_q  <= hold_q  + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
   assign bus.flush_count  = flush_q;
   assign bus.hold_cycles  = hold_q;
`else
   assign bus.stall_cycles = '0;
   assign bus.flush_count  = '0;
   assign bus.hold_cycles  = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks in-flight destination registers over `DEPTH` post-decode stages and generates forwarding selects for both EX operands. It also issues load-use stalls with a configurable load-to-use distance, handles branch flushes, and applies a global hold while data memory is busy. It sits beside the datapath and drives the PC enable, the IF/ID and ID/EX control, and the EX operand muxes.

## Interface
- `RF_ADDRESS`, 5: register-address width.
- `DEPTH`, 3: tracked stages after ID (entry 0 = EX, entry `DEPTH-1` = WB); legal range 2..7.
- `LOAD_USE_DIST`, 1: number of youngest tracked stages whose load result cannot be forwarded; legal range 1..`DEPTH-1`.
- `FWD_W`, `$clog2(DEPTH)`: forward-select width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in `RF_ADDRESS`: ID source registers.
- `id_uses_rs1`, `id_uses_rs2` in 1: the source is actually read.
- `id_rd` in `RF_ADDRESS`: ID destination register.
- `id_reg_write`, `id_mem_read` in 1: ID writes the register file / is a load.
- `ex_flush` in 1: taken branch or jump resolved in EX.
- `mem_busy` in 1: data memory not ready; the whole pipeline must freeze.
- `if_stall` out 1: hold PC and IF/ID.
- `id_bubble` out 1: load NOP into ID/EX.
- `if_id_flush`, `id_ex_flush` out 1: clear IF/ID and ID/EX.
- `pipe_hold` out 1: freeze every stage register.
- `fwd_a`, `fwd_b` out `FWD_W`: EX operand source. 0 = register file; k = result of tracked entry k (1..`DEPTH-1`).
- `stall_cycles`, `flush_count`, `hold_cycles` out 32: performance counters.

## Operation
- State:
  - `inflight[0..DEPTH-1]`, each holding {valid, rd, reg_write, mem_read}.
  - `ex_rs1`, `ex_rs2`, `ex_use1`, `ex_use2` for the instruction in EX.
- Match rule: entry valid, reg_write=1, rd≠0, rd equals the source register, and the source's use bit is set. x0 never matches.
- `pipe_hold = mem_busy`.
  - While asserted, no state changes.
  - `if_stall`=1; `id_bubble`, `if_id_flush` and `id_ex_flush` are 0.
  - A pending `ex_flush` is therefore deferred. The branch stays in EX and re-asserts `ex_flush` next cycle.
- Flush: when `ex_flush`=1 and there is no hold:
  - `if_id_flush`=`id_ex_flush`=1 and `if_stall`=0.
  - Flush has priority over load-use; `id_bubble` is 0.
- Load-use: when `id_valid`=1, `ex_flush`=0 and there is no hold, and any entry k < `LOAD_USE_DIST` with mem_read=1 matches `id_rs1` or `id_rs2`:
  - `if_stall`=`id_bubble`=1.
- Advance on every un-held edge:
  - `inflight[k] <= inflight[k-1]`.
  - `inflight[0]` takes the ID fields with valid=`id_valid` & !`id_bubble` & !`ex_flush`; otherwise it is invalid.
  - The `ex_rs*`/`ex_use*` fields are captured the same way, with use bits cleared when invalid.
- Forwarding: `fwd_a` is the smallest k ≥ 1 whose entry matches `ex_rs1`, or 0 if none (youngest wins). `fwd_b` is computed the same way for `ex_rs2`.
  - Entry 0 is never a source, because it is the EX instruction itself.
  - Loads in entries below `LOAD_USE_DIST` cannot be selected, because the stall rule guarantees the consumer is never in EX at that point.

## Timing
- `if_stall`, `id_bubble`, the flush outputs and `pipe_hold` are combinational from inputs and state, so they are valid in the same cycle.
- `fwd_a` and `fwd_b` are combinational from registered state only; there is no input-to-output path.
- Load-use penalty is `LOAD_USE_DIST` cycles. Flush penalty is 2 bubbles.
- Reset (asynchronous, takes effect mid-operation):
  - All entries invalid, `ex_use*`=0, counters 0.
  - With inputs idle, every output is 0.
- Simultaneous `mem_busy` and `ex_flush`: the hold wins. Simultaneous `ex_flush` and load-use: the flush wins.

## Configuration
- `HAZ_PERF_EN` defined:
  - `stall_cycles` increments on each cycle with load-use `if_stall`.
  - `flush_count` increments on each cycle with `if_id_flush`.
  - `hold_cycles` increments on each cycle with `pipe_hold`.
  - All three saturate at 0xFFFF_FFFF and are cleared by reset.
- `HAZ_PERF_EN` undefined: no counter flops are built; the three outputs are tied to 0.

## Structure
- Package `haz_ctrl_pkg` holds:
  - the `inflight_t` struct {valid, rd, reg_write, mem_read};
  - the `FWD_RF` = 0 constant;
  - the legal-parameter checks as localparams/elaboration asserts.
- Sub-module `fwd_select`: combinational youngest-match priority encoder over `inflight[1..DEPTH-1]`, instantiated once per operand.

## Test plan
- Defaults. `add x5` in ID, then `sub x6,x5,x1` → next cycle in EX `fwd_a`=1; one instruction later the same consumer gives `fwd_a`=2. A write to x0 gives `fwd_a`=0.
- Load-use. `lw x7` in EX (entry 0) with ID `add x8,x7,x7` → `if_stall`=`id_bubble`=1 for 1 cycle. The consumer then reaches EX with `fwd_a`=`fwd_b`=2.
- With `LOAD_USE_DIST`=2 and `DEPTH`=4, the same sequence → 2 stall cycles, then `fwd_a`=3.
- `ex_flush` pulse while ID holds a load-use hazard → `if_id_flush`=`id_ex_flush`=1, `if_stall`=0, and `inflight[0]` is invalid next cycle.
- `mem_busy` held 3 cycles with `ex_flush`=1 → flushes stay 0 and state is frozen. The flush is applied on the first un-held cycle. With `HAZ_PERF_EN`, `hold_cycles`=3 and `flush_count`=1.
- Assert reset while forwarding is active → `fwd_a`, `fwd_b` and all stall/flush outputs drop to 0 immediately, and the counters clear.
